// File: rtl/pipe_hazard_ctrl.sv
// Y86 five-stage pipeline hazard controller: load-use, ret, mispredict and sticky halt.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_hazard_ctrl #(
    parameter int         RET_BUBBLES = 3,
    parameter int         CNT_W       = 16,
    parameter logic [3:0] RNONE       = 4'hF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       W_icode,
    input  logic             stats_clr,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_mispred,
    output logic [CNT_W-1:0] cnt_ret,
    output logic [CNT_W-1:0] cnt_cycles
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam int RL_W = (RET_BUBBLES > 1) ? $clog2(RET_BUBBLES) : 1;
    localparam logic [RL_W-1:0] RET_INIT = RL_W'(RET_BUBBLES - 1);
    localparam logic [RL_W-1:0] RET_LAST = RL_W'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    state_t          state_r;
    logic [RL_W-1:0] ret_left_r;

    logic lu_s, mp_s, rt_s, hlt_s;
    logic ev_lu_s, ev_mp_s, ev_rt_s;

    // Raw hazard conditions decoded from the pipeline registers.
    always_comb begin
        lu_s  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp_s  = (E_icode == I_JXX) && !e_Cnd;
        rt_s  = (D_icode == I_RET);
        hlt_s = (W_icode == I_HALT);
    end

    // Prioritised control decode; halt dominates, and in RET_WAIT only halt can interrupt.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        ev_lu_s  = 1'b0;
        ev_mp_s  = 1'b0;
        ev_rt_s  = 1'b0;
        halted   = (state_r == S_HALTED);
        case (state_r)
            S_RUN: begin
                if (hlt_s) begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                end else if (mp_s) begin
                    D_bubble = 1'b1;
                    E_bubble = 1'b1;
                    ev_mp_s  = 1'b1;
                end else if (lu_s) begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    E_bubble = 1'b1;
                    ev_lu_s  = 1'b1;
                end else if (rt_s) begin
                    F_stall  = 1'b1;
                    D_bubble = 1'b1;
                    ev_rt_s  = 1'b1;
                end else begin
                    F_stall  = 1'b0;
                end
            end
            S_RET_WAIT: begin
                if (hlt_s) begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                end else begin
                    F_stall  = 1'b1;
                    D_bubble = 1'b1;
                end
            end
            S_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: begin
                F_stall  = 1'b0;
            end
        endcase
    end

    // Control FSM: ret wait window countdown and sticky halt.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_RUN;
            ret_left_r <= RL_W'(0);
        end else begin
            case (state_r)
                S_RUN: begin
                    if (hlt_s) begin
                        state_r <= S_HALTED;
                    end else if (ev_rt_s && (RET_BUBBLES > 1)) begin
                        state_r    <= S_RET_WAIT;
                        ret_left_r <= RET_INIT;
                    end
                end
                S_RET_WAIT: begin
                    if (hlt_s) begin
                        state_r <= S_HALTED;
                    end else if (ret_left_r == RET_LAST) begin
                        state_r <= S_RUN;
                    end else begin
                        ret_left_r <= ret_left_r - RET_LAST;
                    end
                end
                S_HALTED: state_r <= S_HALTED;
                default:  state_r <= S_RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // Saturating event counters; clear has priority over any increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_loaduse <= CNT_W'(0);
            cnt_mispred <= CNT_W'(0);
            cnt_ret     <= CNT_W'(0);
            cnt_cycles  <= CNT_W'(0);
        end else if (stats_clr) begin
            cnt_loaduse <= CNT_W'(0);
            cnt_mispred <= CNT_W'(0);
            cnt_ret     <= CNT_W'(0);
            cnt_cycles  <= CNT_W'(0);
        end else begin
            cnt_loaduse <= sat_inc(cnt_loaduse, ev_lu_s);
            cnt_mispred <= sat_inc(cnt_mispred, ev_mp_s);
            cnt_ret     <= sat_inc(cnt_ret, ev_rt_s);
            cnt_cycles  <= sat_inc(cnt_cycles, state_r != S_HALTED);
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = stats_clr ^ ev_lu_s ^ ev_mp_s;
    assign cnt_loaduse = CNT_W'(0);
    assign cnt_mispred = CNT_W'(0);
    assign cnt_ret     = CNT_W'(0);
    assign cnt_cycles  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl; expected control vectors are queued as
// stimulus is applied and popped when the combinational outputs are sampled.
module tb_pipe_hazard_ctrl;

    localparam int TB_CNT_W = 4;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_LU     = 7'b1101000;
    localparam logic [6:0] C_MP     = 7'b0011000;
    localparam logic [6:0] C_RT     = 7'b1010000;
    localparam logic [6:0] C_HLT    = 7'b1100110;
    localparam logic [6:0] C_HALTED = 7'b1100111;

    logic clock = 1'b0;
    logic reset_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, W_icode;
    logic e_Cnd, stats_clr;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [TB_CNT_W-1:0] cnt_loaduse, cnt_mispred, cnt_ret, cnt_cycles;
    logic [6:0] obs;
    logic [6:0] exp_v;
    logic [6:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    assign obs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted};

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.RET_BUBBLES(3), .CNT_W(TB_CNT_W), .RNONE(4'hF)) dut (
        .clock(clock), .reset_n(reset_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .W_icode(W_icode),
        .stats_clr(stats_clr),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted),
        .cnt_loaduse(cnt_loaduse), .cnt_mispred(cnt_mispred),
        .cnt_ret(cnt_ret), .cnt_cycles(cnt_cycles)
    );

    task automatic idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1; W_icode = 4'h1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stats_clr = 1'b0;
        idle();
        #12;
        exp_q.push_back(C_NONE);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_ctrl: got %b want %b", obs, exp_v); end
        checks++;
        if ({cnt_loaduse, cnt_mispred, cnt_ret, cnt_cycles} !== 16'h0000) begin
            errors++; $display("FAIL reset_cnt: got %h want 0", {cnt_loaduse, cnt_mispred, cnt_ret, cnt_cycles});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_loaduse();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        exp_q.push_back(C_LU);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL loaduse: got %b want %b", obs, exp_v); end
        tick();
        idle();
        exp_q.push_back(C_NONE);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL loaduse_clear: got %b want %b", obs, exp_v); end
        tick();
    endtask

    task automatic test_rnone();
        E_icode = 4'hB; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        exp_q.push_back(C_NONE);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rnone_nomatch: got %b want %b", obs, exp_v); end
        tick();
        idle();
    endtask

    task automatic test_ret();
        logic [3:0] dic [4];
        logic [6:0] ex  [4];
        dic = '{4'h9, 4'h1, 4'h1, 4'h1};
        ex  = '{C_RT, C_RT, C_RT, C_NONE};
        for (int i = 0; i < 4; i++) begin
            D_icode = dic[i];
            exp_q.push_back(ex[i]);
            @(negedge clock);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL ret_window[%0d]: got %b want %b", i, obs, exp_v); end
            tick();
        end
    endtask

    task automatic test_priority();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; D_icode = 4'h9;
        exp_q.push_back(C_LU);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lu_over_ret: got %b want %b", obs, exp_v); end
        tick();
        idle();
        exp_q.push_back(C_NONE);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lu_no_retwait: got %b want %b", obs, exp_v); end
        tick();
    endtask

    task automatic test_mispredict();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
        exp_q.push_back(C_MP);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mispred: got %b want %b", obs, exp_v); end
        tick();
        idle();
        exp_q.push_back(C_NONE);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mispred_no_retwait: got %b want %b", obs, exp_v); end
`ifdef PIPE_CTRL_STATS_EN
        checks++;
        if (cnt_mispred !== 4'd1) begin errors++; $display("FAIL cnt_mispred: got %0d want 1", cnt_mispred); end
        checks++;
        if (cnt_ret !== 4'd0) begin errors++; $display("FAIL cnt_ret_killed: got %0d want 0", cnt_ret); end
`else
        checks++;
        if (cnt_mispred !== 4'd0) begin errors++; $display("FAIL cnt_mispred_tied: got %0d want 0", cnt_mispred); end
`endif
        tick();
    endtask

    task automatic test_halt();
        D_icode = 4'h9;
        exp_q.push_back(C_RT);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL halt_ret: got %b want %b", obs, exp_v); end
        tick();
        D_icode = 4'h1; W_icode = 4'h0;
        exp_q.push_back(C_HLT);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL halt_in_retwait: got %b want %b", obs, exp_v); end
        tick();
        W_icode = 4'h1;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(C_HALTED);
            @(negedge clock);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL halted_hold[%0d]: got %b want %b", i, obs, exp_v); end
            tick();
        end
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(C_NONE);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset_exit: got %b want %b", obs, exp_v); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_stats_saturate();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(C_LU);
            @(negedge clock);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lu_burst[%0d]: got %b want %b", i, obs, exp_v); end
            tick();
        end
        idle();
        @(negedge clock);
`ifdef PIPE_CTRL_STATS_EN
        checks++;
        if (cnt_loaduse !== 4'd15) begin errors++; $display("FAIL cnt_loaduse_sat: got %0d want 15", cnt_loaduse); end
        checks++;
        if (cnt_cycles !== 4'd15) begin errors++; $display("FAIL cnt_cycles_sat: got %0d want 15", cnt_cycles); end
        tick();
        stats_clr = 1'b1;
        tick();
        @(negedge clock);
        checks++;
        if ({cnt_loaduse, cnt_mispred, cnt_ret, cnt_cycles} !== 16'h0000) begin
            errors++; $display("FAIL stats_clr: got %h want 0", {cnt_loaduse, cnt_mispred, cnt_ret, cnt_cycles});
        end
        stats_clr = 1'b0;
`else
        checks++;
        if (cnt_loaduse !== 4'd0) begin errors++; $display("FAIL cnt_loaduse_tied: got %0d want 0", cnt_loaduse); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_rnone();
        test_ret();
        test_priority();
        test_mispredict();
        test_halt();
        test_stats_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
